// File: rtl/instr_reg_scheduler.sv
// instr_reg_scheduler: round-robin write arbiter and circular-queue pointer manager for instr_register
module instr_reg_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_operand_a,
  input  logic [NUM_REQ*32-1:0] req_operand_b,
  input  logic [NUM_REQ*4-1:0] req_opcode,
  output logic                 load_en,
  output logic [31:0]          operand_a,
  output logic [31:0]          operand_b,
  output logic [3:0]           opcode,
  output logic [PTR_W-1:0]     write_pointer,
  output logic [PTR_W-1:0]     read_pointer,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [PTR_W:0]       count,
  output logic                 full,
  output logic                 empty
);
  localparam int DEPTH = 2 ** PTR_W;
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [RW-1:0]      rr, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic               found, xfer, pop;
  logic [PTR_W:0]     stored;
  logic [PTR_W-1:0]   wptr, rptr;
  assign req_ready     = gnt;
  assign xfer          = |gnt;
  assign rd_valid      = stored != '0;
  assign pop           = rd_valid & rd_ready;
  assign full          = count == (PTR_W+1)'(DEPTH);
  assign empty         = count == '0;
  assign write_pointer = wptr;
  assign read_pointer  = rptr;
  // round-robin search starting at rr; full counts the in-flight entry so no unread slot is overwritten
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid[RW'((int'(rr) + j) % NUM_REQ)]) begin
        found = 1'b1;
        gidx  = RW'((int'(rr) + j) % NUM_REQ);
      end
    end
    if (found && reset_n && !full) gnt[gidx] = 1'b1;
  end
  // winner register, pointers and occupancy; wptr advances as each registered load is issued
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_en   <= 1'b0;
      operand_a <= '0;
      operand_b <= '0;
      opcode    <= '0;
      rr        <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      stored    <= '0;
    end else begin
      load_en <= xfer;
      if (xfer) begin
        operand_a <= req_operand_a[32*gidx +: 32];
        operand_b <= req_operand_b[32*gidx +: 32];
        opcode    <= req_opcode[4*gidx +: 4];
        rr        <= RW'((int'(gidx) + 1) % NUM_REQ);
      end
      if (load_en) wptr <= wptr + PTR_W'(1);
      if (pop) rptr <= rptr + PTR_W'(1);
      count  <= count + (PTR_W+1)'(xfer) - (PTR_W+1)'(pop);
      stored <= stored + (PTR_W+1)'(load_en) - (PTR_W+1)'(pop);
    end
  end
endmodule
